// File: rtl/m_ucodeseq_pkg.sv
// Shared microcode sequencer definitions: seqop encodings, fixed vectors and
// control-word field layout, also consumed by the microcode assembler output.
package m_ucodeseq_pkg;

  typedef enum logic [1:0] {
    SEQ_JUMP     = 2'b00,
    SEQ_DISPATCH = 2'b01,
    SEQ_BRANCH   = 2'b10,
    SEQ_MEMWAIT  = 2'b11
  } seqop_t;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_STALL_MEM  = 2'b01,
    ST_STALL_DISP = 2'b10
  } state_t;

  localparam logic [7:0] RESET_VEC  = 8'h00;
  localparam logic [7:0] TRAP_VEC   = 8'h04;
  localparam logic [7:0] BUSERR_VEC = 8'h08;

  localparam int SA_LSB     = 0;
  localparam int SEQOP_LSB  = 8;
  localparam int IRQ_EN_BIT = 10;
  localparam int CTL_W      = 11;

  // Packed so that the struct overlays d[10:0] bit-for-bit.
  typedef struct packed {
    logic       irq_en;
    seqop_t     seqop;
    logic [7:0] sa_next;
  } ctl_t;

  function automatic ctl_t unpack_ctl(input logic [CTL_W-1:0] f);
    return ctl_t'(f);
  endfunction

endpackage

// File: rtl/m_ucodewdog.sv
// Memory-stall watchdog: saturating counter with clear/increment and a flag
// raised when the count reaches WDOG_LIMIT-1.
module m_ucodewdog #(
  parameter int WDOG_LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WDOG_LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == LAST);

endmodule

// File: rtl/m_ucodeseq.sv
// Microcode sequencer: picks the next ROM address from the registered control
// word, holds the address during memory/dispatch stalls, and redirects on
// interrupt or memory-stall timeout.
module m_ucodeseq
  import m_ucodeseq_pkg::*;
#(
  parameter int         WDOG_LIMIT = 256,
  parameter logic [2:0] DISP_BASE  = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] d,
  input  logic [4:0]  instr_class,
  input  logic        instr_valid,
  input  logic        cond,
  input  logic        mem_busy,
  input  logic        irq_req,
  output logic [7:0]  minx,
  output logic        progress_ucode,
  output logic        stalled,
  output logic        trap_taken,
  output logic        buserr
);

  ctl_t       ctl;
  state_t     state, state_nx;
  logic [7:0] held;
  logic       wd_hit, wd_inc;
  logic       unused_d;

  assign ctl      = unpack_ctl(d[CTL_W-1:0]);
  assign unused_d = ^d[47:CTL_W];

  always_comb begin
    minx           = held;
    progress_ucode = 1'b0;
    trap_taken     = 1'b0;
    buserr         = 1'b0;
    wd_inc         = 1'b0;
    state_nx       = state;
    if (rst) begin
      minx           = RESET_VEC;
      progress_ucode = 1'b1;
    end else begin
      unique case (ctl.seqop)
        SEQ_JUMP: begin
          minx           = ctl.sa_next;
          progress_ucode = 1'b1;
        end
        SEQ_BRANCH: begin
          minx           = {ctl.sa_next[7:1], cond};
          progress_ucode = 1'b1;
        end
        SEQ_DISPATCH: begin
          // Interrupt takes priority over a pending instruction.
          if (ctl.irq_en && irq_req) begin
            minx           = TRAP_VEC;
            progress_ucode = 1'b1;
            trap_taken     = 1'b1;
          end else if (instr_valid) begin
            minx           = {DISP_BASE, instr_class};
            progress_ucode = 1'b1;
          end else begin
            state_nx = ST_STALL_DISP;
          end
        end
        SEQ_MEMWAIT: begin
          // A transfer completing in the timeout cycle is a normal exit.
          if (!mem_busy) begin
            minx           = ctl.sa_next;
            progress_ucode = 1'b1;
          end else if (wd_hit) begin
            minx           = BUSERR_VEC;
            progress_ucode = 1'b1;
            buserr         = 1'b1;
          end else begin
            state_nx = ST_STALL_MEM;
            wd_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (progress_ucode) state_nx = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      held    <= RESET_VEC;
      stalled <= 1'b0;
    end else begin
      state   <= state_nx;
      stalled <= (state_nx != ST_RUN);
      if (progress_ucode) held <= minx;
    end
  end

  m_ucodewdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(progress_ucode),
    .inc(wd_inc),
    .hit(wd_hit)
  );

endmodule

// File: doc/m_ucodeseq.md
M_UCODESEQ -- requirements
Module: m_ucodeseq

Interface
REQ-001 Parameters (name, default, meaning): WDOG_LIMIT, 256, consecutive memory-stall cycles before a bus-error redirect; DISP_BASE, 3'b111, upper 3 bits of the dispatch address.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 d  in  48  registered control word from the microcode ROM; sequencer uses d[7:0] sa_next, d[9:8] seqop, d[10] irq_en.
REQ-005 instr_class  in  5  decoded instruction class, meaningful when instr_valid=1.
REQ-006 instr_valid  in  1  instruction available for dispatch.
REQ-007 cond  in  1  branch condition from the datapath.
REQ-008 mem_busy  in  1  bus transfer not yet complete.
REQ-009 irq_req  in  1  interrupt pending, level.
REQ-010 minx  out  8  ROM read address (combinational).
REQ-011 progress_ucode  out  1  ROM read enable (combinational); 0 = hold current d.
REQ-012 stalled  out  1  registered; 1 while state is STALL_MEM or STALL_DISP.
REQ-013 trap_taken  out  1  one-cycle combinational pulse when an interrupt is dispatched.
REQ-014 buserr  out  1  one-cycle combinational pulse on watchdog redirect.

Function
REQ-015 ROM contract: minx sampled with progress_ucode=1 at edge t yields d for that address from edge t onward, held while progress_ucode=0.
REQ-016 seqop 00 JUMP: minx=sa_next, progress_ucode=1.
REQ-017 seqop 10 BRANCH: minx={sa_next[7:1],cond}, progress_ucode=1.
REQ-018 seqop 01 DISPATCH: irq_en&irq_req -> minx=8'h04 (TRAP_VEC), progress=1, trap_taken=1; else instr_valid -> minx={DISP_BASE,instr_class}, progress=1; else progress=0, next state STALL_DISP.
REQ-019 Interrupt wins over instr_valid when both present in the same DISPATCH cycle.
REQ-020 seqop 11 MEMWAIT: mem_busy=0 -> minx=sa_next, progress=1; mem_busy=1 -> progress=0, next state STALL_MEM, watchdog increments.
REQ-021 FSM states RUN, STALL_MEM, STALL_DISP; any cycle with progress_ucode=1 -> RUN; progress_ucode=0 -> stall state per seqop.
REQ-022 Watchdog counter: cleared on every progress_ucode=1 cycle; increments each STALL_MEM cycle; saturates, never wraps.
REQ-023 When the counter equals WDOG_LIMIT-1 and mem_busy=1: minx=8'h08 (BUSERR_VEC), progress=1, buserr=1, counter cleared.
REQ-024 mem_busy falling in the timeout cycle: normal MEMWAIT exit, buserr=0.
REQ-025 While progress_ucode=0, minx shall equal the last address issued (no glitching address).
REQ-026 STALL_DISP has no timeout; it leaves only via instr_valid, interrupt, or rst.

Reset
REQ-027 While rst=1: minx=8'h00 (RESET_VEC), progress_ucode=1, stalled=0, trap_taken=0, buserr=0, state=RUN, counter=0, held-address register=8'h00.
REQ-028 rst asserted mid-stall overrides all; first cycle after rst=0 executes the word at 8'h00.

Structure
REQ-029 seqop encodings, RESET_VEC, TRAP_VEC, BUSERR_VEC and d field positions in a shared include file used by sequencer and the microcode assembler output.
REQ-030 Watchdog as one sub-module m_ucodewdog (clear, inc, limit-hit out).
REQ-031 Sequencer is instantiated alongside m_3ebr, minx/progress_ucode wired directly to it.

Verification
REQ-032 Release rst, ROM word 0 = JUMP to 8'h10 -> cycle 1 minx=8'h10, progress=1.
REQ-033 BRANCH sa_next=8'h20, cond=1 -> minx=8'h21; cond=0 -> minx=8'h20.
REQ-034 DISPATCH, instr_valid=0 for 3 cycles then 1 with class 5'h0A -> progress=0, stalled=1 for 3 cycles, then minx=8'hEA.
REQ-035 DISPATCH with irq_en=1, irq_req=1, instr_valid=1 -> minx=8'h04, trap_taken=1 for exactly one cycle.
REQ-036 MEMWAIT with mem_busy held high, WDOG_LIMIT=256 -> 255 stall cycles, then minx=8'h08, buserr=1; repeat with mem_busy dropped in cycle 256 -> minx=sa_next, buserr=0.
REQ-037 rst pulse during STALL_MEM -> same cycle minx=8'h00, progress=1; stalled=0 next cycle.
